// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: arbitrates NCH complete-packet sources onto the single UDP
// transmit port, streaming the winner's show-ahead FIFO and counting packets/drops.
module udp_tx_arbiter #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned LW      = 11,
   parameter int unsigned RR_MODE = 1,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              tx_clock,
   input  logic              Tx_reset,
   input  logic              run,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*LW-1:0] ch_len,
   input  logic [NCH*8-1:0]  ch_data,
   output logic [NCH-1:0]    ch_rdreq,
   output logic [NCH-1:0]    ch_grant,
   output logic              udp_tx_request,
   output logic [LW-1:0]     udp_tx_length,
   output logic [7:0]        udp_tx_data,
   input  logic              udp_tx_enable,
   input  logic              udp_tx_active,
   output logic              busy,
   output logic [15:0]       pkt_count,
   output logic [7:0]        drop_count
);

   localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned IW1 = IW + 1;
   localparam int unsigned TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_ACT,
      S_SEND,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [NCH-1:0]  grant_q, grant_d;
   logic            req_q, req_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   rem_q, rem_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [15:0]     pkt_q, pkt_d;
   logic [7:0]      drop_q, drop_d;
   logic            busy_q, busy_d;

   logic [NCH-1:0]  elig;
   logic [IW-1:0]   arb_start;
   logic [IW1-1:0]  arb_sum;
   logic            arb_found;
   logic [IW-1:0]   arb_idx;
   logic [IW-1:0]   g_next;
   logic            give_up;
   logic            data_valid;
   logic            xfer;

   // A channel is eligible only with a pending packet of nonzero length
   always_comb begin
      elig = '0;
      for (int i = 0; i < NCH; i++) begin
         elig[i] = ch_req[i] & (ch_len[i*LW +: LW] != '0);
      end
   end

   assign arb_start = (RR_MODE != 0) ? ptr_q : '0;

   // Search upward from the start index with wrap; first eligible channel wins
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_sum   = '0;
      for (int k = 0; k < NCH; k++) begin
         arb_sum = {1'b0, arb_start} + IW1'(k);
         if (arb_sum >= IW1'(NCH)) begin
            arb_sum = arb_sum - IW1'(NCH);
         end
         if (!arb_found && elig[arb_sum[IW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = arb_sum[IW-1:0];
         end
      end
   end

   assign g_next = (gidx_q == IW'(NCH - 1)) ? '0 : gidx_q + IW'(1);

   // Zero-latency data path: byte and pop are presented in the same cycle
   assign data_valid  = ((state_q == S_WAIT_ACT) || (state_q == S_SEND)) && (rem_q != '0);
   assign xfer        = data_valid && udp_tx_active;
   assign ch_rdreq    = xfer ? grant_q : '0;
   assign udp_tx_data = data_valid ? ch_data[32'(gidx_q)*8 +: 8] : 8'h00;

   // Next-state and registered-output computation
   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      len_d   = len_q;
      rem_d   = rem_q;
      timer_d = timer_q + TW'(1);
      ptr_d   = ptr_q;
      pkt_d   = pkt_q;
      drop_d  = drop_q;
      give_up = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (run && arb_found) begin
               state_d = S_REQ;
               gidx_d  = arb_idx;
               grant_d = NCH'(1) << arb_idx;
               len_d   = ch_len[32'(arb_idx)*LW +: LW];
               rem_d   = ch_len[32'(arb_idx)*LW +: LW];
            end
         end
         S_REQ: begin
            if (udp_tx_enable) begin
               state_d = S_WAIT_ACT;
               timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT)) begin
               give_up = 1'b1;
            end
         end
         S_WAIT_ACT: begin
            if (udp_tx_active) begin
               timer_d = '0;
               rem_d   = rem_q - LW'(1);
               state_d = (rem_q == LW'(1)) ? S_DONE : S_SEND;
            end else if (timer_q == TW'(TIMEOUT)) begin
               give_up = 1'b1;
            end
         end
         S_SEND: begin
            timer_d = '0;
            if (udp_tx_active) begin
               rem_d = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = S_DONE;
               end
            end else begin
               give_up = 1'b1;
            end
         end
         S_DONE: begin
            timer_d = '0;
            pkt_d   = pkt_q + 16'd1;
            ptr_d   = g_next;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Timeout or abort: drop the packet and move the pointer past the stuck channel
      if (give_up) begin
         state_d = S_IDLE;
         timer_d = '0;
         ptr_d   = g_next;
         if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end

      if (state_d == S_IDLE) begin
         grant_d = '0;
      end
      req_d  = (state_d == S_REQ);
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge tx_clock or posedge Tx_reset) begin
      if (Tx_reset) begin
         state_q <= S_IDLE;
         gidx_q  <= '0;
         grant_q <= '0;
         req_q   <= 1'b0;
         len_q   <= '0;
         rem_q   <= '0;
         timer_q <= '0;
         ptr_q   <= '0;
         pkt_q   <= '0;
         drop_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         req_q   <= req_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         timer_q <= timer_d;
         ptr_q   <= ptr_d;
         pkt_q   <= pkt_d;
         drop_q  <= drop_d;
         busy_q  <= busy_d;
      end
   end

   assign ch_grant       = grant_q;
   assign udp_tx_request = req_q;
   assign udp_tx_length  = len_q;
   assign busy           = busy_q;
   assign pkt_count      = pkt_q;
   assign drop_count     = drop_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: per-cycle behavioural model plus directed scenarios.
module tb_udp_tx_arbiter;

   localparam int unsigned NCH = 4;
   localparam int unsigned LW  = 11;
   localparam int unsigned TO  = 15;

   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_WAIT = 2;
   localparam int P_SEND = 3;
   localparam int P_DONE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              run;
   logic [NCH-1:0]    ch_req;
   logic [NCH*LW-1:0] ch_len;
   logic [NCH*8-1:0]  ch_data;
   logic              en;
   logic              act;

   logic [NCH-1:0]    rdreq, grant;
   logic              req;
   logic [LW-1:0]     len;
   logic [7:0]        data;
   logic              busy;
   logic [15:0]       pkt;
   logic [7:0]        drop;

   logic [NCH-1:0]    f_rdreq, f_grant;
   logic              f_req;
   logic [LW-1:0]     f_len;
   logic [7:0]        f_data;
   logic              f_busy;
   logic [15:0]       f_pkt;
   logic [7:0]        f_drop;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   udp_tx_arbiter #(.NCH(NCH), .LW(LW), .RR_MODE(1), .TIMEOUT(TO)) u_dut (
      .tx_clock(clk), .Tx_reset(rst), .run(run), .ch_req(ch_req), .ch_len(ch_len),
      .ch_data(ch_data), .ch_rdreq(rdreq), .ch_grant(grant), .udp_tx_request(req),
      .udp_tx_length(len), .udp_tx_data(data), .udp_tx_enable(en), .udp_tx_active(act),
      .busy(busy), .pkt_count(pkt), .drop_count(drop)
   );

   udp_tx_arbiter #(.NCH(NCH), .LW(LW), .RR_MODE(0), .TIMEOUT(TO)) u_fix (
      .tx_clock(clk), .Tx_reset(rst), .run(run), .ch_req(ch_req), .ch_len(ch_len),
      .ch_data(ch_data), .ch_rdreq(f_rdreq), .ch_grant(f_grant), .udp_tx_request(f_req),
      .udp_tx_length(f_len), .udp_tx_data(f_data), .udp_tx_enable(en), .udp_tx_active(act),
      .busy(f_busy), .pkt_count(f_pkt), .drop_count(f_drop)
   );

   // Show-ahead source FIFOs: channel i head byte is A0 + 16*i + bytes popped so far
   int unsigned rdcnt [NCH] = '{0, 0, 0, 0};
   always @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rdreq[i]) rdcnt[i] <= rdcnt[i] + 1;
      end
   end
   always_comb begin
      ch_data = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_data[i*8 +: 8] = 8'(32'hA0 + 32'(i) * 16 + rdcnt[i]);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model of the round-robin arbiter (packet phase, bytes left, wait time)
   int m_ph = 0, m_g = 0, m_len = 0, m_rem = 0, m_t = 0, m_ptr = 0, m_pkt = 0, m_drop = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph <= P_IDLE; m_g <= 0; m_len <= 0; m_rem <= 0;
         m_t <= 0; m_ptr <= 0; m_pkt <= 0; m_drop <= 0;
      end else begin : step
         automatic int ph = m_ph, g = m_g, ln = m_len, rem = m_rem, t = m_t;
         automatic int ptr = m_ptr, pk = m_pkt, dr = m_drop, c = 0;
         automatic bit quit = 1'b0;
         case (ph)
            P_IDLE: if (run) begin
               for (int k = 0; k < NCH; k++) begin
                  c = (ptr + k) % NCH;
                  if (ph == P_IDLE && ch_req[c] && ch_len[c*LW +: LW] != 0) begin
                     g = c; ln = int'(ch_len[c*LW +: LW]); rem = ln; ph = P_REQ; t = 0;
                  end
               end
            end
            P_REQ: begin
               if (en) begin ph = P_WAIT; t = 0; end
               else if (t == TO) quit = 1'b1;
               else t++;
            end
            P_WAIT: begin
               if (act) begin rem--; ph = (rem == 0) ? P_DONE : P_SEND; end
               else if (t == TO) quit = 1'b1;
               else t++;
            end
            P_SEND: begin
               if (act) begin rem--; if (rem == 0) ph = P_DONE; end
               else quit = 1'b1;
            end
            default: begin
               pk = (pk + 1) % 65536; ptr = (g + 1) % NCH; ph = P_IDLE;
            end
         endcase
         if (quit) begin
            ph = P_IDLE; ptr = (g + 1) % NCH;
            if (dr < 255) dr++;
         end
         m_ph <= ph; m_g <= g; m_len <= ln; m_rem <= rem; m_t <= t;
         m_ptr <= ptr; m_pkt <= pk; m_drop <= dr;
      end
   end

   // Per-cycle comparison against the model, plus a log of popped bytes
   int unsigned rd_total = 0;
   logic [7:0]  rd_bytes [$];

   always @(negedge clk) begin : cmp
      automatic logic [NCH-1:0] one = 1;
      automatic logic [NCH-1:0] e_grant;
      automatic logic [NCH-1:0] e_rd;
      automatic logic [7:0]     e_data;
      automatic bit             dv;
      e_grant = (m_ph != P_IDLE) ? (one << m_g) : '0;
      dv      = (m_ph == P_WAIT || m_ph == P_SEND) && (m_rem != 0);
      e_rd    = (dv && act) ? e_grant : '0;
      e_data  = dv ? ch_data[m_g*8 +: 8] : 8'h00;
      check("grant",  32'(grant), 32'(e_grant));
      check("rdreq",  32'(rdreq), 32'(e_rd));
      check("data",   32'(data),  32'(e_data));
      check("req",    32'(req),   32'(m_ph == P_REQ));
      check("length", 32'(len),   32'(m_len));
      check("busy",   32'(busy),  32'(m_ph != P_IDLE));
      check("pkt",    32'(pkt),   32'(m_pkt));
      check("drop",   32'(drop),  32'(m_drop));
      if (rdreq != '0) begin
         rd_total++;
         rd_bytes.push_back(data);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         if (req) ok = 1'b1;
         else begin tick(1); n++; end
      end
      check("req_wait", 32'(ok), 32'd1);
   endtask

   task automatic handshake(input int en_dly, input int act_n);
      tick(en_dly);
      en = 1'b1;
      tick(1);
      en  = 1'b0;
      act = 1'b1;
      tick(act_n);
      act = 1'b0;
   endtask

   task automatic set_len(input int ch, input int value);
      ch_len[ch*LW +: LW] = LW'(value);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      bit ok;
      int base, base_pkt, n;
      logic [NCH-1:0] g_rr [8];
      logic [NCH-1:0] g_fx [8];
      logic [NCH-1:0] exp_rr [8];

      rst = 1'b1; run = 1'b0; ch_req = '0; ch_len = '0; en = 1'b0; act = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_pkt",   32'(pkt),   32'd0);

      // Single 5-byte packet, enable 2 cycles late, active held 7 cycles
      set_len(0, 5); ch_req = 4'b0001; run = 1'b1;
      wait_req(ok);
      ch_req = '0;
      check("t1_len",   32'(len),   32'd5);
      check("t1_grant", 32'(grant), 32'b0001);
      base = rd_bytes.size();
      handshake(2, 7);
      tick(2);
      check("t1_rdcnt", 32'(rd_bytes.size() - base), 32'd5);
      for (int k = 0; k < 5; k++) check("t1_byte", 32'(rd_bytes[base + k]), 32'hA0 + 32'(k));
      check("t1_pkt", 32'(pkt), 32'd1);

      // Round robin versus fixed priority, all channels requesting 3-byte packets
      rst = 1'b1; tick(1); rst = 1'b0;
      for (int i = 0; i < NCH; i++) set_len(i, 3);
      ch_req = 4'b1111;
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int p = 0; p < 8; p++) begin
         wait_req(ok);
         g_rr[p] = grant;
         g_fx[p] = f_grant;
         handshake(0, 3);
      end
      ch_req = '0;
      tick(3);
      for (int p = 0; p < 8; p++) begin
         check("t2_rr_grant",  32'(g_rr[p]), 32'(exp_rr[p]));
         check("t2_fix_grant", 32'(g_fx[p]), 32'b0001);
      end
      check("t2_pkt",     32'(pkt),   32'd8);
      check("t2_fix_pkt", 32'(f_pkt), 32'd8);

      // Request timeout, then the next requesting channel gets the port
      rst = 1'b1; tick(1); rst = 1'b0;
      set_len(0, 4); set_len(2, 4); ch_req = 4'b0101;
      wait_req(ok);
      n = 0;
      while (req && n < 100) begin n++; tick(1); end
      check("t3_req_cycles", 32'(n),    32'd16);
      check("t3_drop",       32'(drop), 32'd1);
      wait_req(ok);
      check("t3_next_grant", 32'(grant), 32'b0100);
      ch_req = '0;
      handshake(0, 4);
      tick(2);
      // Enable given but active never comes: WAIT_ACT timeout
      set_len(1, 4); ch_req = 4'b0010;
      wait_req(ok);
      ch_req = '0;
      en = 1'b1; tick(1); en = 1'b0;
      tick(20);
      check("t3_wait_drop", 32'(drop), 32'd2);
      check("t3_idle",      32'(busy), 32'd0);

      // Abort: 100-byte packet, active falls after 40 bytes
      set_len(0, 100); ch_req = 4'b0001;
      wait_req(ok);
      ch_req = '0;
      base = int'(rd_total);
      base_pkt = int'(pkt);
      handshake(0, 40);
      tick(3);
      check("t4_rdcnt", 32'(int'(rd_total) - base), 32'd40);
      check("t4_drop",  32'(drop), 32'd3);
      check("t4_pkt",   32'(pkt),  32'(base_pkt));
      check("t4_idle",  32'(busy), 32'd0);

      // Asynchronous reset in the middle of SEND
      set_len(0, 10); ch_req = 4'b0001;
      wait_req(ok);
      ch_req = '0;
      en = 1'b1; tick(1); en = 1'b0;
      act = 1'b1;
      tick(3);
      #1 rst = 1'b1;
      #1;
      check("t5_grant", 32'(grant), 32'd0);
      check("t5_req",   32'(req),   32'd0);
      check("t5_rdreq", 32'(rdreq), 32'd0);
      check("t5_data",  32'(data),  32'd0);
      check("t5_busy",  32'(busy),  32'd0);
      check("t5_pkt",   32'(pkt),   32'd0);
      check("t5_drop",  32'(drop),  32'd0);
      check("t5_len",   32'(len),   32'd0);
      #1 rst = 1'b0;
      tick(1);
      base = int'(rd_total);
      tick(5);
      check("t5_no_rdreq", 32'(int'(rd_total) - base), 32'd0);
      act = 1'b0;

      // Zero-length channel never granted; nothing granted while run is low
      run = 1'b0;
      set_len(0, 0); set_len(1, 2); set_len(2, 2); ch_req = 4'b0111;
      tick(10);
      check("t6_hold_busy",  32'(busy),  32'd0);
      check("t6_hold_grant", 32'(grant), 32'd0);
      run = 1'b1;
      wait_req(ok);
      check("t6_grant1", 32'(grant), 32'b0010);
      handshake(0, 2);
      wait_req(ok);
      check("t6_grant2", 32'(grant), 32'b0100);
      ch_req = '0;
      handshake(0, 2);
      tick(3);
      check("t6_pkt",  32'(pkt),  32'd2);
      check("t6_idle", 32'(busy), 32'd0);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
